// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN frame loader and its frame buffer.
package cnn_pkg;

  localparam int DATA_W  = 32;
  localparam int IMG_DIM = 8;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int PTR_W   = 6;
  localparam int TMO_W   = 13;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_DROP   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESULT = 3'd4
  } loader_state_e;

  // Most negative DATA_W value, reported when the core never finishes.
  localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 32'h8000_0000;

endpackage

// File: rtl/cnn_frame_buf.sv
// NPIX x DATA_W register file with one write port and a flattened read-out.
module cnn_frame_buf #(
  parameter int DATA_W = 32,
  parameter int NPIX   = 64,
  parameter int PTR_W  = 6
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [PTR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]      i_data,
  output logic [DATA_W*NPIX-1:0] o_flat
);

  logic [DATA_W-1:0] r_mem [NPIX];

  // Pixel storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  for (genvar g = 0; g < NPIX; g++) begin : g_flat
    assign o_flat[g*DATA_W +: DATA_W] = r_mem[g];
  end

endmodule

// File: rtl/cnn_frame_loader.sv
// Frame ingress, CNN core sequencing and result egress for one 8x8 image.
// Optional watchdog in RUN enabled by defining CNN_LOADER_TIMEOUT_EN.
module cnn_frame_loader #(
  parameter int DATA_W      = cnn_pkg::DATA_W,
  parameter int IMG_DIM     = cnn_pkg::IMG_DIM,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_W-1:0]                 s_data,
  input  logic                              s_last,
  output logic [DATA_W*IMG_DIM*IMG_DIM-1:0] img_flat,
  output logic                              core_rst,
  output logic                              core_enable,
  input  logic                              core_done,
  input  logic [DATA_W-1:0]                 core_value,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_W-1:0]                 m_data,
  output logic                              frame_err,
  output logic                              timeout
);
  import cnn_pkg::*;

  localparam int NPIX_L  = IMG_DIM * IMG_DIM;
  localparam int PTR_W_L = $clog2(NPIX_L);
  localparam logic [PTR_W_L-1:0] LAST_PTR = PTR_W_L'(NPIX_L - 1);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 8192) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYC must fit the 13-bit watchdog");
  end

  loader_state_e       r_state;
  logic [PTR_W_L-1:0]  r_wr_ptr;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_frame_err;
  logic                r_timeout;
  logic                w_s_ready;
  logic                w_core_rst;
  logic                w_core_en;
  logic                w_m_valid;
  logic                w_beat;
  logic                w_we;

`ifdef CNN_LOADER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]    r_tmo_cnt;
`endif

  // Handshake and core controls decoded from the registered state.
  always_comb begin
    w_s_ready  = 1'b0;
    w_core_rst = rst;
    w_core_en  = 1'b0;
    w_m_valid  = 1'b0;
    case (r_state)
      ST_FILL, ST_DROP: w_s_ready  = 1'b1;
      ST_CLEAR:         w_core_rst = 1'b1;
      ST_RUN:           w_core_en  = 1'b1;
      ST_RESULT:        w_m_valid  = 1'b1;
      default:          w_s_ready  = 1'b0;
    endcase
    w_beat = s_valid & w_s_ready;
    w_we   = w_beat & (r_state == ST_FILL);
  end

  // Loader FSM: framing, core run, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_wr_ptr    <= {PTR_W_L{1'b0}};
      r_m_data    <= {DATA_W{1'b0}};
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef CNN_LOADER_TIMEOUT_EN
      r_tmo_cnt   <= {TMO_W{1'b0}};
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_beat) begin
            if (r_wr_ptr == LAST_PTR) begin
              r_wr_ptr <= {PTR_W_L{1'b0}};
              if (s_last) begin
                r_state <= ST_CLEAR;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_DROP;
              end
            end else if (s_last) begin
              r_frame_err <= 1'b1;
              r_wr_ptr    <= {PTR_W_L{1'b0}};
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W_L'(1);
            end
          end
        end
        ST_DROP: begin
          if (w_beat && s_last) begin
            r_state <= ST_FILL;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_RUN;
`ifdef CNN_LOADER_TIMEOUT_EN
          r_tmo_cnt <= {TMO_W{1'b0}};
`endif
        end
        ST_RUN: begin
          // A done arriving on the expiry cycle takes priority over the watchdog.
          if (core_done) begin
            r_m_data <= core_value;
            r_state  <= ST_RESULT;
          end
`ifdef CNN_LOADER_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_m_data  <= TIMEOUT_RESULT;
            r_state   <= ST_RESULT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 13'd1;
          end
`endif
        end
        ST_RESULT: begin
          if (m_ready) begin
            r_state <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  cnn_frame_buf #(
    .DATA_W (DATA_W),
    .NPIX   (NPIX_L),
    .PTR_W  (PTR_W_L)
  ) u_frame_buf (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (r_wr_ptr),
    .i_data (s_data),
    .o_flat (img_flat)
  );

  assign s_ready     = w_s_ready;
  assign core_rst    = w_core_rst;
  assign core_enable = w_core_en;
  assign m_valid     = w_m_valid;
  assign m_data      = r_m_data;
  assign frame_err   = r_frame_err;
`ifdef CNN_LOADER_TIMEOUT_EN
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader with a behavioural CNN core stand-in.
module tb_cnn_frame_loader;

`ifdef CNN_LOADER_TIMEOUT_EN
  localparam int TCYC   = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TCYC   = 4096;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] TMO_VAL = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [31:0]   s_data = 32'd0;
  logic          core_done = 1'b0;
  logic [31:0]   core_value = 32'd0;
  logic          m_ready = 1'b0;
  logic          s_ready, core_rst, core_enable, m_valid, frame_err, timeout;
  logic [31:0]   m_data;
  logic [2047:0] img_flat;

  always #5 clk = ~clk;

  cnn_frame_loader #(.DATA_W(32), .IMG_DIM(8), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .img_flat(img_flat), .core_rst(core_rst), .core_enable(core_enable),
    .core_done(core_done), .core_value(core_value), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .frame_err(frame_err), .timeout(timeout)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          err_exp = 0, err_seen = 0, en_cnt = 0, crst_cnt = 0;
  bit          mr_rand = 1'b0;
  logic [31:0] pix [0:127];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stand-in for the CNN core's result: position-weighted sum of the frame.
  function automatic logic [31:0] sig(input logic [2047:0] flat);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 64; i++) s += flat[i*32 +: 32] * (i + 1);
    return s;
  endfunction

  // Behavioural core: sticky done after 'lat' enabled cycles; lat 0 = never.
  initial begin
    bit armed = 1'b0;
    int lat = 0, cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (core_rst) begin
        core_done = 1'b0; cnt = 0; armed = 1'b1;
      end else if (core_enable) begin
        if (armed) begin
          armed = 1'b0;
          if (lat_q.size() != 0) lat = lat_q.pop_front();
          else begin lat = 0; check("unexpected_run", 1, 0); end
        end
        cnt++;
        if (lat != 0 && cnt == lat && !core_done) begin
          core_done = 1'b1; core_value = sig(img_flat);
        end
      end
    end
  end

  // Monitor: result scoreboard and event counters.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) err_seen++;
      if (core_rst) begin crst_cnt++; en_cnt = 0; end
      else if (core_enable) en_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mr_rand) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_frame(input int n, input bit gaps);
    for (int b = 0; b < n; b++) begin
      bit rdy = 1'b0;
      int guard = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = pix[b]; s_last = (b == n - 1);
      while (!rdy && guard < 2000) begin
        @(negedge clk); rdy = s_ready; @(posedge clk); #1; guard++;
      end
      s_valid = 1'b0; s_last = 1'b0;
      if (!rdy) begin check("beat_accept_timeout", 0, 1); return; end
      check("frame_err_beat", frame_err, ((n < 64 && b == n - 1) || (n > 64 && b == 63)));
    end
  endtask

  // Reference: only exact 64-beat frames run the core; others raise one framing error.
  task automatic do_frame(input int n, input int lat, input bit gaps, input bit push, input bit ramp);
    logic [2047:0] flat;
    for (int i = 0; i < n; i++) pix[i] = ramp ? 32'(i) : $urandom;
    for (int i = 0; i < 64; i++) flat[i*32 +: 32] = pix[i];
    if (n == 64) begin
      lat_q.push_back(lat);
      if (push) exp_q.push_back((TMO_EN && (lat == 0 || lat > TCYC)) ? TMO_VAL : sig(flat));
    end else begin
      err_exp++;
    end
    send_frame(n, gaps);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !s_ready) && g < 1000) begin @(posedge clk); #1; g++; end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int g, bad, n, r;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_core_rst", core_rst, 1);
    check("rst_core_en", core_enable, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_core_rst", core_rst, 0);

    // Ramp frame, result held back by m_ready=0.
    crst_cnt = 0;
    do_frame(64, 10, 1'b0, 1'b1, 1'b1);
    g = 0;
    while (!m_valid && g < 200) begin @(posedge clk); #1; g++; end
    check("m_valid_seen", m_valid, 1);
    check("core_en_cycles", en_cnt, 10);
    check("core_rst_cycles", crst_cnt, 1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (img_flat[i*32 +: 32] !== 32'(i)) bad++;
    check("img_flat_ramp", bad, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_data", m_data, 32'd87360);
      check("hold_s_ready", s_ready, 0);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1;
    check("accept_s_ready", s_ready, 1);
    check("accept_m_valid", m_valid, 0);
    m_ready = 1'b0; mr_rand = 1'b1;

    // Short frame, then a good one.
    crst_cnt = 0;
    do_frame(21, 0, 1'b1, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("short_no_core_rst", crst_cnt, 0);
    check("short_s_ready", s_ready, 1);
    do_frame(64, $urandom_range(1, 20), 1'b1, 1'b1, 1'b0);

    // Long frame, then a good one; then done/watchdog boundary latencies.
    do_frame(70, 0, 1'b1, 1'b1, 1'b0);
    do_frame(64, $urandom_range(1, 20), 1'b1, 1'b1, 1'b0);
    do_frame(64, 16, 1'b0, 1'b1, 1'b0);
    do_frame(64, 17, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      n = (r < 7) ? 64 : (r < 8) ? $urandom_range(1, 63) : $urandom_range(65, 80);
      do_frame(n, $urandom_range(1, 20), 1'b1, 1'b1, 1'b0);
    end
    drain();

    // Reset while the core runs: frame is abandoned, no result.
    do_frame(64, 0, 1'b0, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("run_before_rst", core_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_run_core_rst", core_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_run_s_ready", s_ready, 1);
    check("rst_in_run_core_en", core_enable, 0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (m_valid) bad++; end
    check("rst_in_run_no_result", bad, 0);

`ifdef CNN_LOADER_TIMEOUT_EN
    mr_rand = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    do_frame(64, 0, 1'b0, 1'b1, 1'b0);
    bad = 0;
    repeat (17) begin @(negedge clk); if (timeout || m_valid) bad++; end
    check("no_early_timeout", bad, 0);
    @(negedge clk);
    check("timeout_pulse", timeout, 1);
    check("timeout_m_valid", m_valid, 1);
    check("timeout_m_data", m_data, TMO_VAL);
    check("timeout_en_cycles", en_cnt, 16);
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
    @(posedge clk); #1;
    mr_rand = 1'b1;
    drain();
`endif

    repeat (5) begin @(posedge clk); #1; end
    check("exp_q_empty", exp_q.size(), 0);
    check("lat_q_empty", lat_q.size(), 0);
    check("frame_err_count", err_seen, err_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/cnn_frame_loader.md
Name: cnn_frame_loader

Overview:
Ingress/egress stage directly upstream of the CNN core (conv -> pool -> fc).
- Accepts an 8x8 image as a valid/ready pixel stream and assembles it into a 64-word frame buffer.
- Resets and enables the core, then waits for its done flag.
- Captures the scalar result and returns it on an output valid/ready handshake.
- Owns the per-frame core reset, because the core latches done and needs a reset between frames.

Parameters:
- DATA_W, 32, pixel and result width (signed two's complement).
- IMG_DIM, 8, image side; frame holds IMG_DIM*IMG_DIM = 64 pixels.
- TIMEOUT_CYC, 4096, watchdog limit in RUN (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  pixel valid.
- s_ready  out  1  loader can accept a pixel.
- s_data  in  DATA_W  pixel, row-major order.
- s_last  in  1  marks the final pixel of a frame.
- img_flat  out  DATA_W*64  frame buffer; pixel i is at bits [i*DATA_W +: DATA_W].
- core_rst  out  1  reset to the CNN core.
- core_enable  out  1  level enable to the CNN core.
- core_done  in  1  core completion (sticky until core reset).
- core_value  in  DATA_W  core result.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted downstream.
- m_data  out  DATA_W  captured result.
- frame_err  out  1  one-cycle pulse on a framing error.
- timeout  out  1  one-cycle pulse on a watchdog expiry.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state=FILL, wr_ptr=0;
  - s_ready=1 from the next cycle;
  - core_rst=1, core_enable=0;
  - m_valid=0, m_data=0, frame_err=0, timeout=0.
  - img_flat contents are not reset; they are don't-care until the first frame is written.
- States are FILL, DROP, CLEAR, RUN, RESULT. s_ready=1 only in FILL and DROP.
- Outputs decoded from state: core_rst=1 in CLEAR or while rst=1; core_enable=1 only in RUN.
- FILL: on s_valid&s_ready, write s_data to buf[wr_ptr].
  - s_last=1 and wr_ptr=63: go to CLEAR and set wr_ptr=0.
  - s_last=1 and wr_ptr<63 (short frame): pulse frame_err, set wr_ptr=0, stay in FILL. The partial frame is discarded.
  - s_last=0 and wr_ptr=63 (long frame): pulse frame_err, set wr_ptr=0, go to DROP.
  - Otherwise increment wr_ptr. wr_ptr never wraps silently.
- DROP: consume beats without writing. On the beat with s_last=1, go to FILL.
- CLEAR: lasts one cycle (core_rst=1), then go to RUN. img_flat is frozen from CLEAR through RESULT.
- RUN: core_enable=1. When core_done=1, register m_data<=core_value and go to RESULT.
  - core_done is ignored in every other state.
- RESULT: m_valid=1 with m_data stable.
  - On m_valid&m_ready, go to FILL. The next frame can start on the following cycle.
  - m_valid never drops without acceptance.
- Latency:
  - Last pixel accepted at edge T: core_rst=1 during T..T+1, core_enable=1 from T+1.
  - core_done seen at edge D: m_valid=1 from D.
  - Loader overhead is 2 cycles plus the core latency.
- s_valid while s_ready=0 is legal; the beat is held upstream and not consumed.
- rst mid-frame or mid-RUN: the partial frame is discarded and core_rst asserts. No m_valid for that frame.

Optional Feature:
- Macro CNN_LOADER_TIMEOUT_EN.
- Defined: a 13-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC-1 with core_done=0: pulse timeout, set m_data=signed minimum (0x80000000), go to RESULT.
  - core_done on that same cycle wins; no timeout is raised.
- Undefined: no counter; RUN waits indefinitely; timeout is tied to 0.

Decomposition:
- Package cnn_pkg holds:
  - DATA_W, IMG_DIM, NPIX=64, PTR_W=6;
  - the loader state enum;
  - the TIMEOUT_RESULT constant.
- One natural sub-module, cnn_frame_buf: a 64xDATA_W register file with write port (we, addr, data) and the flattened read-out. The loader FSM stays in the top.

Test Plan:
- Send 64 beats s_data=i (0..63) with s_last on beat 63; core model asserts done after 10 cycles with value 0x00001234.
  - Expect img_flat word i = i, one core_rst cycle, core_enable for 10 cycles, m_valid with m_data=0x1234.
- Hold m_ready=0 for 5 cycles in RESULT.
  - Expect m_valid and m_data stable and s_ready=0.
  - Then m_ready=1: expect FILL and s_ready=1 on the next cycle.
- Short frame: s_last on beat 20.
  - Expect frame_err pulse, wr_ptr=0, no core_rst.
  - A following good frame completes normally.
- Long frame: 70 beats, s_last on beat 69.
  - Expect frame_err on beat 63 and beats 64-69 dropped.
  - The next 64-beat frame completes normally.
- Assert rst while in RUN.
  - Expect state FILL, core_enable=0, core_rst=1, and no m_valid.
- With CNN_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, core never asserts done.
  - Expect a timeout pulse 16 cycles into RUN and m_data=0x80000000.
